// File: rtl/sram_pkg.sv
// Shared constants, FSM encoding and helpers for the byte-lane dual-port SRAM.
package sram_pkg;

  localparam int RD_READ_OLD   = 0;
  localparam int RD_WRITE_THRU = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic int lanes_f(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_lane.sv
// One 8-bit byte lane: single write port, two registered read ports with a
// configurable same-address collision policy.
module sram_lane
  import sram_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int RD_MODE = RD_READ_OLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic              re_a_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [7:0]        rdata_a_o,
  input  logic              re_b_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [7:0]        rdata_b_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_a_q, rdata_a_d;
  logic [7:0] rdata_b_q, rdata_b_d;
  logic       fwd_a, fwd_b;

  // Write-through forwards the incoming byte; read-old relies on the
  // non-blocking array update so the read sees pre-write contents.
  assign fwd_a = (RD_MODE == RD_WRITE_THRU) && we_i && (waddr_i == raddr_a_i);
  assign fwd_b = (RD_MODE == RD_WRITE_THRU) && we_i && (waddr_i == raddr_b_i);

  always_comb begin
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    if (re_a_i) rdata_a_d = fwd_a ? wdata_i : mem_q[raddr_a_i];
    if (re_b_i) rdata_b_d = fwd_b ? wdata_i : mem_q[raddr_b_i];
  end

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a_q <= 8'h00;
      rdata_b_q <= 8'h00;
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/param_dual_port_sram.sv
// Parametrised byte-lane RAM: read-only fetch port, read/write load/store port,
// and a post-reset clear sequencer that zeroes the array.
module param_dual_port_sram
  import sram_pkg::*;
#(
  parameter  int DATA_W       = 32,
  parameter  int ADDR_W       = 10,
  localparam int LANES        = lanes_f(DATA_W),
  parameter  int RD_MODE      = RD_READ_OLD,
  parameter  int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] abus1,
  input  logic              re1,
  output logic [DATA_W-1:0] dbus1,
  output logic              rvalid1,
  input  logic [ADDR_W-1:0] abus2,
  input  logic              re2,
  input  logic [LANES-1:0]  bwe,
  input  logic [DATA_W-1:0] dbus2i,
  output logic [DATA_W-1:0] dbus2o,
  output logic              rvalid2,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              rvalid1_q, rvalid2_q;
  logic              busy_w;
  logic              re1_m, re2_m;
  logic [ADDR_W-1:0] waddr_w;
  logic [DATA_W-1:0] wdata_w;
  logic [LANES-1:0]  we_w;

  assign busy_w = (state_q == ST_CLEAR);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == {ADDR_W{1'b1}}) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt_q <= '0;
      rvalid1_q <= 1'b0;
      rvalid2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rvalid1_q <= re1_m;
      rvalid2_q <= re2_m;
    end
  end

  // While clearing, the sequencer owns the write port and user traffic is dropped.
  assign re1_m   = re1 & ~busy_w;
  assign re2_m   = re2 & ~busy_w;
  assign waddr_w = busy_w ? clr_cnt_q : abus2;
  assign wdata_w = busy_w ? '0 : dbus2i;
  assign we_w    = busy_w ? {LANES{1'b1}} : bwe;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    sram_lane #(
      .ADDR_W  (ADDR_W),
      .RD_MODE (RD_MODE)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .we_i      (we_w[gi]),
      .waddr_i   (waddr_w),
      .wdata_i   (wdata_w[8*gi +: 8]),
      .re_a_i    (re1_m),
      .raddr_a_i (abus1),
      .rdata_a_o (dbus1[8*gi +: 8]),
      .re_b_i    (re2_m),
      .raddr_b_i (abus2),
      .rdata_b_o (dbus2o[8*gi +: 8])
    );
  end

  assign rvalid1 = rvalid1_q;
  assign rvalid2 = rvalid2_q;
  assign busy    = busy_w;

endmodule

// File: tb/tb_param_dual_port_sram.sv
// Bench for param_dual_port_sram: read-old and write-through instances share
// stimulus; a reference memory feeds per-port expected-data queues.
module tb_param_dual_port_sram;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int LN    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, re1, re2;
  logic [AW-1:0] abus1, abus2;
  logic [LN-1:0] bwe;
  logic [DW-1:0] dbus2i;

  logic [DW-1:0] d1_0, d2_0, d1_1, d2_1;
  logic          rv1_0, rv2_0, rv1_1, rv2_1, busy_0, busy_1;

  param_dual_port_sram #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(0), .CLEAR_ON_RST(1)) dut0 (
    .clk(clk), .rst(rst), .abus1(abus1), .re1(re1), .dbus1(d1_0), .rvalid1(rv1_0),
    .abus2(abus2), .re2(re2), .bwe(bwe), .dbus2i(dbus2i), .dbus2o(d2_0),
    .rvalid2(rv2_0), .busy(busy_0));

  param_dual_port_sram #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(1), .CLEAR_ON_RST(1)) dut1 (
    .clk(clk), .rst(rst), .abus1(abus1), .re1(re1), .dbus1(d1_1), .rvalid1(rv1_1),
    .abus2(abus2), .re2(re2), .bwe(bwe), .dbus2i(dbus2i), .dbus2o(d2_1),
    .rvalid2(rv2_1), .busy(busy_1));

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] mem [DEPTH];
  int            busy_cnt = 0;
  logic [DW-1:0] q1a[$], q2a[$], q1b[$], q2b[$];
  logic [DW-1:0] last1a = '0, last2a = '0, last1b = '0, last2b = '0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic clr_in();
    re1 = 0; re2 = 0; bwe = '0; abus1 = '0; abus2 = '0; dbus2i = '0;
  endtask

  // One clock: update model from current inputs, clock, then check all outputs.
  task automatic step();
    logic          wr, ev;
    logic [DW-1:0] merged, ed;
    wr = 1'b0;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      busy_cnt = DEPTH;
      q1a.delete(); q2a.delete(); q1b.delete(); q2b.delete();
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end else begin
      wr = |bwe;
      merged = mem[abus2];
      for (int l = 0; l < LN; l++) if (bwe[l]) merged[8*l +: 8] = dbus2i[8*l +: 8];
      if (re1) begin
        q1a.push_back(mem[abus1]);
        q1b.push_back((wr && abus2 == abus1) ? merged : mem[abus1]);
      end
      if (re2) begin
        q2a.push_back(mem[abus2]);
        q2b.push_back(wr ? merged : mem[abus2]);
      end
      if (wr) mem[abus2] = merged;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      last1a = '0; last2a = '0; last1b = '0; last2b = '0;
      chk("rst_rv1", 32'(rv1_0 | rv1_1), '0);
      chk("rst_rv2", 32'(rv2_0 | rv2_1), '0);
      chk("rst_d_m0", d1_0 | d2_0, '0);
      chk("rst_d_m1", d1_1 | d2_1, '0);
    end else begin
      ev = (q1a.size() > 0); ed = ev ? q1a.pop_front() : last1a; last1a = ed;
      chk("p1_m0_rvalid", 32'(rv1_0), 32'(ev)); chk("p1_m0_data", d1_0, ed);
      ev = (q2a.size() > 0); ed = ev ? q2a.pop_front() : last2a; last2a = ed;
      chk("p2_m0_rvalid", 32'(rv2_0), 32'(ev)); chk("p2_m0_data", d2_0, ed);
      ev = (q1b.size() > 0); ed = ev ? q1b.pop_front() : last1b; last1b = ed;
      chk("p1_m1_rvalid", 32'(rv1_1), 32'(ev)); chk("p1_m1_data", d1_1, ed);
      ev = (q2b.size() > 0); ed = ev ? q2b.pop_front() : last2b; last2b = ed;
      chk("p2_m1_rvalid", 32'(rv2_1), 32'(ev)); chk("p2_m1_data", d2_1, ed);
    end
    chk("busy_m0", 32'(busy_0), 32'(busy_cnt > 0));
    chk("busy_m1", 32'(busy_1), 32'(busy_cnt > 0));
  endtask

  task automatic idle(input int n);
    clr_in();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LN-1:0] be);
    clr_in(); abus2 = a; dbus2i = d; bwe = be; step();
  endtask

  task automatic rd1(input logic [AW-1:0] a);
    clr_in(); abus1 = a; re1 = 1; step();
  endtask

  task automatic reset_pulse();
    clr_in(); rst = 1; step(); rst = 0;
  endtask

  initial begin
    rst = 1;
    clr_in();
    step();
    step();
    rst = 0;
    idle(DEPTH + 1);

    // Reset clear over a pre-loaded array
    for (int a = 0; a < DEPTH; a++) wr(AW'(a), 32'hDEADBEEF, 4'b1111);
    reset_pulse();
    idle(DEPTH);
    for (int a = 0; a < DEPTH; a++) begin
      clr_in(); abus1 = AW'(a); re1 = 1; abus2 = AW'(DEPTH - 1 - a); re2 = 1; step();
    end
    idle(1);

    // Byte-enable write
    wr(4'd5, 32'h11223344, 4'b1111);
    wr(4'd5, 32'hAABBCCDD, 4'b0101);
    rd1(4'd5);
    idle(1);

    // Collision on both ports
    wr(4'd7, 32'h01020304, 4'b1111);
    clr_in(); abus1 = 4'd7; re1 = 1; abus2 = 4'd7; re2 = 1; bwe = 4'b0011;
    dbus2i = 32'hFFFFFFFF; step();
    clr_in(); abus1 = 4'd7; re1 = 1; abus2 = 4'd7; re2 = 1; step();
    idle(1);

    // Hold behaviour
    wr(4'd2, 32'hCAFEF00D, 4'b1111);
    rd1(4'd2);
    idle(3);

    // Busy masking and mid-clear reset
    wr(4'd3, 32'h55AA55AA, 4'b1111);
    reset_pulse();
    for (int i = 0; i < 7; i++) begin
      clr_in(); abus2 = 4'd3; bwe = 4'b1111; dbus2i = 32'h12345678; re1 = 1; re2 = 1; step();
    end
    reset_pulse();
    for (int i = 0; i < DEPTH; i++) begin
      clr_in(); abus2 = 4'd3; bwe = 4'b1111; dbus2i = 32'h12345678; re1 = 1; re2 = 1; step();
    end
    clr_in(); abus1 = 4'd3; re1 = 1; abus2 = 4'd3; re2 = 1; step();
    idle(1);

    // Mixed random traffic
    for (int i = 0; i < 40; i++) begin
      clr_in();
      abus1  = AW'($urandom_range(0, DEPTH - 1));
      abus2  = AW'($urandom_range(0, 3));
      re1    = 1'($urandom_range(0, 1));
      re2    = 1'($urandom_range(0, 1));
      bwe    = LN'($urandom_range(0, 15));
      dbus2i = $urandom();
      step();
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/param_dual_port_sram.md
Name: param_dual_port_sram

Overview:
Parametrised byte-lane synchronous RAM for the MIPS1000 memory subsystem. It is the generalised successor to the fixed 32-bit, four-lane instruction/data SRAM.
- Port 1 is read-only (instruction fetch).
- Port 2 is read/write with per-lane byte enables (load/store).
- Adds configurable width and depth, per-port read-valid flags, a defined same-address read/write collision policy, and a post-reset memory-clear sequencer with a busy indication.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8.
ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W words.
LANES, DATA_W/8, number of byte lanes (derived; not overridden).
RD_MODE, 0, collision policy: 0 = read-old (read-first), 1 = write-through (new data forwarded).
CLEAR_ON_RST, 1, 1 = zero the whole array after reset; 0 = no clear, busy never asserts.

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
abus1  in  ADDR_W  port 1 word address
re1  in  1  port 1 read enable
dbus1  out  DATA_W  port 1 read data (registered)
rvalid1  out  1  dbus1 holds data from the read issued in the previous cycle
abus2  in  ADDR_W  port 2 word address (shared by read and write)
re2  in  1  port 2 read enable
bwe  in  LANES  port 2 byte write enables; bit i writes dbus2i[8i+7:8i]
dbus2i  in  DATA_W  port 2 write data
dbus2o  out  DATA_W  port 2 read data (registered)
rvalid2  out  1  dbus2o holds data from the read issued in the previous cycle
busy  out  1  clear sequence in progress; all requests are ignored

Behaviour:
- Reset (rst=1 at an edge):
  - dbus1, dbus2o = 0; rvalid1, rvalid2 = 0.
  - Clear counter = 0; FSM -> CLEAR if CLEAR_ON_RST=1, else IDLE.
  - busy = 1 in the cycle after reset when CLEAR_ON_RST=1.
- FSM states: IDLE, CLEAR.
  - CLEAR: each cycle writes all-zero, all lanes, to address clr_cnt, then clr_cnt++.
  - Exits to IDLE after writing DEPTH-1; busy = 1 for exactly DEPTH cycles after reset release.
  - rst asserted mid-clear restarts the sequence from address 0.
- While busy:
  - re1, re2, bwe are masked; no user write occurs.
  - rvalid1 = rvalid2 = 0; dbus1/dbus2o hold their values.
- Reads:
  - Latency 1: re sampled at edge N -> data on dbus* and rvalid*=1 after edge N.
  - re low -> rvalid low next cycle; dbus* holds its last value (no change).
- Writes:
  - Any bwe bit set at edge N updates the enabled lanes at abus2.
  - Disabled lanes are untouched.
  - bwe = 0 means no write.
  - re2 and bwe may be asserted together.
- Collisions (port 2 write to address A in the same cycle as a read of A on port 1 and/or port 2):
  - RD_MODE=0: the read returns pre-write contents for all lanes.
  - RD_MODE=1: the read returns the merged word: enabled lanes from dbus2i, the others from the array.
  - Port 1 and port 2 obey the same rule.
- Address wrap: ADDR_W covers DEPTH exactly; there are no out-of-range addresses.
- No back-pressure: outside busy, a request is accepted every cycle.
- X-free: the array model is initialised to 0 in simulation as well; after the clear, every read returns defined data.

Decomposition:
- Package sram_pkg holds:
  - RD_READ_OLD / RD_WRITE_THRU constants.
  - FSM state encoding (ST_IDLE, ST_CLEAR).
  - lanes_f(DATA_W) helper.
- Sub-module sram_lane: one 8-bit x DEPTH array with one write port and two registered read ports.
  - Implements the collision mux per RD_MODE.
  - Instantiated LANES times via generate.
- Top level holds the clear FSM/counter, request masking, the shared write-address/data mux (clear vs user), and the rvalid registers.

Test Plan:
1. Reset clear (ADDR_W=4, CLEAR_ON_RST=1): pre-load the array with 0xDEADBEEF, pulse rst one cycle -> busy high for exactly 16 cycles; reads of addresses 0..15 afterwards return 0x00000000 with rvalid1=1.
2. Byte-enable write: write 0x11223344 with bwe=4'b1111 at addr 5, then 0xAABBCCDD with bwe=4'b0101 -> port 1 read of addr 5 returns 0x11BB33DD one cycle after re1.
3. Collision, RD_MODE=0: addr 7 holds 0x01020304; in the same cycle write 0xFFFFFFFF with bwe=4'b0011 and re1=1 @7 -> dbus1=0x01020304; the next read returns 0x0102FFFF.
4. Collision, RD_MODE=1: same stimulus as scenario 3 -> dbus1=0x0102FFFF in the collision cycle; dbus2o matches when re2=1.
5. Busy masking and mid-clear reset: assert bwe=4'b1111 with data 0x12345678 at addr 3 during busy -> addr 3 reads 0 after the clear. Assert rst at clear cycle 8 -> busy restarts and lasts 16 cycles again.
6. Hold behaviour: read addr 2 (0xCAFEF00D), then deassert re1 for 3 cycles -> rvalid1=0 and dbus1 stays 0xCAFEF00D.
